signal_amp_ramp: RTL



---
 rtl/signal_amp_pkg.sv | 28 ++
 rtl/signal_amp_seq.sv | 104 ++++++++++
 rtl/signal_amp_ramp.sv | 105 ++++++++++
 3 files changed

// File: rtl/signal_amp_pkg.sv
// Shared constants for the programmable-gain amplifier: the +0..+20 dB
// coefficient table (unsigned Q4.10), the ramp state type and index helpers.
package signal_amp_pkg;

    localparam int GAIN_MAX_DB = 20;
    localparam int COEF_FRAC   = 10;

    localparam logic [13:0] GAIN_TABLE [0:GAIN_MAX_DB] = '{
        14'd1024, 14'd1149, 14'd1289, 14'd1446, 14'd1623, 14'd1821, 14'd2043,
        14'd2292, 14'd2572, 14'd2886, 14'd3238, 14'd3633, 14'd4077, 14'd4574,
        14'd5132, 14'd5758, 14'd6461, 14'd7249, 14'd8134, 14'd9126, 14'd10240
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } ramp_state_t;

    function automatic logic [4:0] gain_clamp(input logic [4:0] db);
        return (db > 5'(GAIN_MAX_DB)) ? 5'(GAIN_MAX_DB) : db;
    endfunction

    function automatic logic [13:0] gain_coef(input logic [4:0] idx);
        return GAIN_TABLE[gain_clamp(idx)];
    endfunction

endpackage

// File: rtl/signal_amp_seq.sv
// Gain-index sequencer: holds target/current index and BUSY. With
// SIGNAL_AMP_RAMP_EN defined the current index walks 1 dB per RAMP_SAMPLES
// valid samples; otherwise it jumps to the target one cycle after GAIN_SET.
//
//   state | meaning
//   IDLE  | cur_idx == tgt_idx, ramp counter held at 0
//   UP    | cur_idx <  tgt_idx, counting samples before the next +1 dB step
//   DOWN  | cur_idx >  tgt_idx, counting samples before the next -1 dB step
module signal_amp_seq
    import signal_amp_pkg::*;
#(
    parameter int RAMP_SAMPLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [4:0] gain_db,
    input  logic       gain_set,
    output logic [4:0] cur_idx,
    output logic       busy
);

    logic [4:0] tgt_d, tgt_q;
    logic [4:0] cur_d, cur_q;
    logic       busy_d, busy_q;

    always_comb begin
        tgt_d = gain_set ? gain_clamp(gain_db) : tgt_q;
    end

`ifdef SIGNAL_AMP_RAMP_EN
    localparam int CW = (RAMP_SAMPLES > 1) ? $clog2(RAMP_SAMPLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RAMP_SAMPLES - 1);

    ramp_state_t   state_d, state_q;
    logic [CW-1:0] cnt_d, cnt_q;

    always_comb begin
        cur_d = cur_q;
        cnt_d = cnt_q;
        case (state_q)
            UP, DOWN: begin
                if (in_valid) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        cur_d = (state_q == UP) ? cur_q + 5'd1 : cur_q - 5'd1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: cnt_d = '0;
        endcase
        // Landing on the target (by stepping or by a new target) parks the counter.
        if (cur_d == tgt_d) begin
            cnt_d = '0;
        end
        if (cur_d == tgt_d) begin
            state_d = IDLE;
        end else if (cur_d < tgt_d) begin
            state_d = UP;
        end else begin
            state_d = DOWN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    logic unused_ramp_cfg;
    assign unused_ramp_cfg = in_valid ^ (RAMP_SAMPLES > 0);

    always_comb begin
        cur_d = tgt_q;
    end
`endif

    always_comb begin
        busy_d = (cur_d != tgt_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_q  <= '0;
            cur_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            tgt_q  <= tgt_d;
            cur_q  <= cur_d;
            busy_q <= busy_d;
        end
    end

    assign cur_idx = cur_q;
    assign busy    = busy_q;

endmodule

// File: rtl/signal_amp_ramp.sv
// Programmable-gain amplifier (+0..+20 dB): two-stage multiply/saturate
// pipeline and clip counter. Gain ramping is selected by SIGNAL_AMP_RAMP_EN.
module signal_amp_ramp
    import signal_amp_pkg::*;
#(
    parameter int BIT_WIDTH    = 10,
    parameter int RAMP_SAMPLES = 4
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic signed [BIT_WIDTH-1:0] IN,
    input  logic                        IN_VALID,
    input  logic [4:0]                  GAIN_DB,
    input  logic                        GAIN_SET,
    input  logic                        CLIP_CLR,
    output logic signed [BIT_WIDTH-1:0] OUT,
    output logic                        OUT_VALID,
    output logic                        CLIP,
    output logic [7:0]                  CLIP_CNT,
    output logic                        BUSY
);

    localparam int PW = BIT_WIDTH + 15;
    localparam logic signed [PW-1:0] SAT_HI = PW'((2 ** (BIT_WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_LO = PW'(-(2 ** (BIT_WIDTH - 1)));

    logic [4:0]                  cur_idx;
    logic [13:0]                 coef;
    logic signed [PW-1:0]        prod_d, prod_q, sh;
    logic                        v1_d, v1_q;
    logic                        out_valid_d, out_valid_q;
    logic                        clip_d, clip_q;
    logic signed [BIT_WIDTH-1:0] out_d, out_q;
    logic [7:0]                  clip_cnt_d, clip_cnt_q;

    signal_amp_seq #(
        .RAMP_SAMPLES(RAMP_SAMPLES)
    ) u_seq (
        .clk     (CLK),
        .rst     (RESET),
        .in_valid(IN_VALID),
        .gain_db (GAIN_DB),
        .gain_set(GAIN_SET),
        .cur_idx (cur_idx),
        .busy    (BUSY)
    );

    assign coef = gain_coef(cur_idx);

    always_comb begin
        v1_d   = IN_VALID;
        prod_d = prod_q;
        if (IN_VALID) begin
            prod_d = PW'(IN) * PW'($signed({1'b0, coef}));
        end

        sh          = prod_q >>> COEF_FRAC;
        out_valid_d = v1_q;
        out_d       = out_q;
        clip_d      = 1'b0;
        if (v1_q) begin
            if (sh > SAT_HI) begin
                out_d  = SAT_HI[BIT_WIDTH-1:0];
                clip_d = 1'b1;
            end else if (sh < SAT_LO) begin
                out_d  = SAT_LO[BIT_WIDTH-1:0];
                clip_d = 1'b1;
            end else begin
                out_d = sh[BIT_WIDTH-1:0];
            end
        end

        // A clear coincident with a visible clip keeps that clip counted.
        clip_cnt_d = clip_cnt_q;
        if (CLIP_CLR) begin
            clip_cnt_d = {7'd0, clip_q};
        end else if (clip_q && (clip_cnt_q != 8'hFF)) begin
            clip_cnt_d = clip_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            v1_q        <= 1'b0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            clip_q      <= 1'b0;
            clip_cnt_q  <= '0;
        end else begin
            v1_q        <= v1_d;
            prod_q      <= prod_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            clip_q      <= clip_d;
            clip_cnt_q  <= clip_cnt_d;
        end
    end

    assign OUT       = out_q;
    assign OUT_VALID = out_valid_q;
    assign CLIP      = clip_q;
    assign CLIP_CNT  = clip_cnt_q;

endmodule
